// File: rtl/pc_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decode/execute stage.
// Handshake: IMEM_REQ stays high with IMEM_ADDR stable until a cycle with IMEM_ACK=1,
// in which IMEM_RDATA must be valid; PC_LOAD is a one-cycle retire pulse honoured only in READY.
interface pc_fetch_unit_if;
  logic [31:0] NEXT_PC;
  logic        PC_LOAD;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        MISALIGNED;
  logic [31:0] FETCH_COUNT;
  logic [1:0]  state_dbg;

  modport master (
    input  NEXT_PC, PC_LOAD, IMEM_ACK, IMEM_RDATA,
    output PC, PC_PLUS4, IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID,
           MISALIGNED, FETCH_COUNT, state_dbg
  );

  modport slave (
    output NEXT_PC, PC_LOAD, IMEM_ACK, IMEM_RDATA,
    input  PC, PC_PLUS4, IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID,
           MISALIGNED, FETCH_COUNT, state_dbg
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter with a single-outstanding instruction fetch over req/ack.
// All outputs are registered except PC_PLUS4 and IMEM_ADDR, which derive from the PC flop.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RESET,
  pc_fetch_unit_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2,
    HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic        instr_valid_q, instr_valid_d;
  logic        imem_req_q, imem_req_d;
  logic        misaligned_q, misaligned_d;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    fetch_count_d = fetch_count_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    misaligned_d  = misaligned_q;
    case (state_q)
      IDLE: begin
        state_d    = FETCH;
        imem_req_d = 1'b1;
      end
      FETCH: begin
        if (bus.IMEM_ACK) begin
          instr_d       = bus.IMEM_RDATA;
          fetch_count_d = fetch_count_q + 32'd1;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
          state_d       = READY;
        end
      end
      READY: begin
        if (bus.PC_LOAD) begin
          pc_d          = bus.NEXT_PC;
          instr_valid_d = 1'b0;
          // A misaligned target parks the unit until reset; no request is issued for it.
          if (bus.NEXT_PC[1:0] == 2'b00) begin
            imem_req_d = 1'b1;
            state_d    = FETCH;
          end else begin
            misaligned_d = 1'b1;
            state_d      = HALT;
          end
        end
      end
      HALT: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      fetch_count_q <= 32'd0;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_count_q <= fetch_count_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      misaligned_q  <= misaligned_d;
    end
  end

  assign bus.PC          = pc_q;
  assign bus.PC_PLUS4    = pc_q + 32'd4;
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.IMEM_REQ    = imem_req_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.MISALIGNED  = misaligned_q;
  assign bus.FETCH_COUNT = fetch_count_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: reset, streaming, wait states, branch/misalign,
// wrap-around and reset collisions. Inputs change and outputs are sampled on the falling edge.
module tb_pc_fetch_unit;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic CLK = 1'b0;
  logic RESET;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_pc;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_VECTOR(RV)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic ack_cycle(input logic [31:0] data);
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = data;
    tick();
    bus.IMEM_ACK   = 1'b0;
  endtask

  task automatic load_cycle(input logic [31:0] npc);
    bus.NEXT_PC = npc;
    bus.PC_LOAD = 1'b1;
    tick();
    bus.PC_LOAD = 1'b0;
  endtask

  initial begin
    RESET          = 1'b1;
    bus.NEXT_PC    = 32'd0;
    bus.PC_LOAD    = 1'b0;
    bus.IMEM_ACK   = 1'b0;
    bus.IMEM_RDATA = 32'd0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);

    // Reset values
    check("rst_pc",     bus.PC, RV);
    check("rst_instr",  bus.INSTR, 32'd0);
    check("rst_valid",  {31'd0, bus.INSTR_VALID}, 32'd0);
    check("rst_req",    {31'd0, bus.IMEM_REQ}, 32'd0);
    check("rst_mis",    {31'd0, bus.MISALIGNED}, 32'd0);
    check("rst_count",  bus.FETCH_COUNT, 32'd0);
    check("rst_state",  {30'd0, bus.state_dbg}, 32'd0);

    // First fetch
    RESET = 1'b0;
    tick();
    check("first_req",  {31'd0, bus.IMEM_REQ}, 32'd1);
    check("first_addr", bus.IMEM_ADDR, 32'h100);
    check("first_state", {30'd0, bus.state_dbg}, 32'd1);
    ack_cycle(32'h0000_0013);
    check("first_instr", bus.INSTR, 32'h13);
    check("first_valid", {31'd0, bus.INSTR_VALID}, 32'd1);
    check("first_req_lo", {31'd0, bus.IMEM_REQ}, 32'd0);
    check("first_plus4", bus.PC_PLUS4, 32'h104);
    check("first_count", bus.FETCH_COUNT, 32'd1);

    // Sequential stream, two cycles per instruction
    exp_pc = 32'h100;
    for (int i = 1; i < 8; i++) begin
      load_cycle(exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      check("stream_addr",  bus.IMEM_ADDR, exp_pc);
      check("stream_req",   {31'd0, bus.IMEM_REQ}, 32'd1);
      check("stream_vld_lo", {31'd0, bus.INSTR_VALID}, 32'd0);
      ack_cycle(32'h1000_0000 + 32'(i));
      check("stream_instr", bus.INSTR, 32'h1000_0000 + 32'(i));
      check("stream_valid", {31'd0, bus.INSTR_VALID}, 32'd1);
    end
    check("stream_count", bus.FETCH_COUNT, 32'd8);
    check("stream_pc",    bus.PC, 32'h11C);

    // Wait states with an early retire pulse
    load_cycle(32'h120);
    for (int w = 0; w < 3; w++) begin
      check("wait_req",  {31'd0, bus.IMEM_REQ}, 32'd1);
      check("wait_addr", bus.IMEM_ADDR, 32'h120);
      bus.NEXT_PC = 32'hDEAD_0000;
      bus.PC_LOAD = (w == 0);
      tick();
    end
    bus.PC_LOAD = 1'b0;
    check("wait_req4",  {31'd0, bus.IMEM_REQ}, 32'd1);
    check("wait_addr4", bus.IMEM_ADDR, 32'h120);
    ack_cycle(32'hAAAA_0001);
    check("wait_instr", bus.INSTR, 32'hAAAA_0001);
    check("wait_pc",    bus.PC, 32'h120);
    check("wait_count", bus.FETCH_COUNT, 32'd9);
    ack_cycle(32'hBBBB_0002);
    check("stray_instr", bus.INSTR, 32'hAAAA_0001);
    check("stray_count", bus.FETCH_COUNT, 32'd9);
    check("stray_valid", {31'd0, bus.INSTR_VALID}, 32'd1);
    check("stray_state", {30'd0, bus.state_dbg}, 32'd2);

    // Branch, then misaligned target
    load_cycle(32'h2000);
    check("br_addr", bus.IMEM_ADDR, 32'h2000);
    check("br_req",  {31'd0, bus.IMEM_REQ}, 32'd1);
    ack_cycle(32'h0000_1111);
    check("br_count", bus.FETCH_COUNT, 32'd10);
    load_cycle(32'h2002);
    check("mis_flag",  {31'd0, bus.MISALIGNED}, 32'd1);
    check("mis_pc",    bus.PC, 32'h2002);
    check("mis_req",   {31'd0, bus.IMEM_REQ}, 32'd0);
    check("mis_valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("mis_state", {30'd0, bus.state_dbg}, 32'd3);
    bus.IMEM_ACK = 1'b1;
    bus.PC_LOAD  = 1'b1;
    bus.NEXT_PC  = 32'h3000;
    repeat (3) tick();
    bus.IMEM_ACK = 1'b0;
    bus.PC_LOAD  = 1'b0;
    check("halt_req",   {31'd0, bus.IMEM_REQ}, 32'd0);
    check("halt_pc",    bus.PC, 32'h2002);
    check("halt_state", {30'd0, bus.state_dbg}, 32'd3);
    check("halt_count", bus.FETCH_COUNT, 32'd10);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("halt_rst_mis",   {31'd0, bus.MISALIGNED}, 32'd0);
    check("halt_rst_pc",    bus.PC, RV);
    check("halt_rst_count", bus.FETCH_COUNT, 32'd0);
    tick();
    check("refetch_req", {31'd0, bus.IMEM_REQ}, 32'd1);
    ack_cycle(32'h0000_0013);
    check("refetch_valid", {31'd0, bus.INSTR_VALID}, 32'd1);

    // Wrap-around of PC_PLUS4 and FETCH_COUNT
    load_cycle(32'hFFFF_FFFC);
    check("wrap_plus4", bus.PC_PLUS4, 32'h0);
    check("wrap_addr",  bus.IMEM_ADDR, 32'hFFFF_FFFC);
    force dut.fetch_count_q = 32'hFFFF_FFFE;
    tick();
    release dut.fetch_count_q;
    ack_cycle(32'h0000_2222);
    check("wrap_count_max", bus.FETCH_COUNT, 32'hFFFF_FFFF);
    load_cycle(32'h0);
    check("wrap_addr0", bus.IMEM_ADDR, 32'h0);
    check("wrap_req",   {31'd0, bus.IMEM_REQ}, 32'd1);
    ack_cycle(32'h0000_3333);
    check("wrap_count0", bus.FETCH_COUNT, 32'd0);

    // Reset coincident with ACK
    load_cycle(32'h40);
    bus.IMEM_ACK   = 1'b1;
    bus.IMEM_RDATA = 32'h0000_0077;
    RESET          = 1'b1;
    tick();
    RESET        = 1'b0;
    bus.IMEM_ACK = 1'b0;
    check("rack_count", bus.FETCH_COUNT, 32'd0);
    check("rack_instr", bus.INSTR, 32'd0);
    check("rack_valid", {31'd0, bus.INSTR_VALID}, 32'd0);
    check("rack_req",   {31'd0, bus.IMEM_REQ}, 32'd0);
    check("rack_pc",    bus.PC, RV);
    check("rack_state", {30'd0, bus.state_dbg}, 32'd0);
    tick();
    check("rack_req2", {31'd0, bus.IMEM_REQ}, 32'd1);
    ack_cycle(32'h0000_0055);
    check("rack_count1", bus.FETCH_COUNT, 32'd1);

    // Reset coincident with PC_LOAD
    bus.NEXT_PC = 32'h300;
    bus.PC_LOAD = 1'b1;
    RESET       = 1'b1;
    tick();
    RESET       = 1'b0;
    bus.PC_LOAD = 1'b0;
    check("rld_pc",    bus.PC, RV);
    check("rld_count", bus.FETCH_COUNT, 32'd0);
    check("rld_state", {30'd0, bus.state_dbg}, 32'd0);
    check("rld_req",   {31'd0, bus.IMEM_REQ}, 32'd0);
    check("rld_instr", bus.INSTR, 32'd0);
    tick();
    check("rld_req2",  {31'd0, bus.IMEM_REQ}, 32'd1);
    check("rld_addr",  bus.IMEM_ADDR, RV);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

- Holds the architectural program counter and fetches one instruction word per PC value from instruction memory over a req/ack handshake.
- Presents the fetched word to the decode/execute stage.
- Produces PC+4 for input I0 of the next-PC 2:1 32-bit multiplexer; the branch target drives I1.
- Loads the multiplexer output Y back into the PC when the processor retires the current instruction.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
- CLK  input  1  single system clock; all state updates on its rising edge.
- RESET  input  1  synchronous, active-high reset.
- NEXT_PC  input  32  next PC from the next-PC multiplexer output Y.
- PC_LOAD  input  1  retire pulse: load NEXT_PC and start the next fetch.
- PC  output  32  current PC register.
- PC_PLUS4  output  32  PC + 4, combinational, feeds multiplexer I0.
- IMEM_ADDR  output  32  fetch address; always equals PC.
- IMEM_REQ  output  1  fetch request, held high until acknowledged.
- IMEM_ACK  input  1  memory acknowledge; IMEM_RDATA is valid in the same cycle.
- IMEM_RDATA  input  32  instruction word from memory.
- INSTR  output  32  latched instruction word.
- INSTR_VALID  output  1  INSTR corresponds to the current PC.
- MISALIGNED  output  1  sticky flag: a misaligned NEXT_PC was loaded.
- FETCH_COUNT  output  32  number of completed fetches; wraps modulo 2^32.

## Operation
- States: IDLE, FETCH, READY, HALT.
- Reset values:
  - state = IDLE, PC = RESET_VECTOR, INSTR = 0.
  - INSTR_VALID = 0, IMEM_REQ = 0, MISALIGNED = 0, FETCH_COUNT = 0.
- IDLE -> FETCH unconditionally on the first edge with RESET low.
- FETCH:
  - IMEM_REQ = 1, IMEM_ADDR = PC.
  - On IMEM_ACK = 1: INSTR <= IMEM_RDATA, FETCH_COUNT <= FETCH_COUNT + 1, go to READY.
  - Otherwise stay in FETCH with the request held and the address stable.
- READY:
  - INSTR_VALID = 1, IMEM_REQ = 0.
  - On PC_LOAD = 1: PC <= NEXT_PC and INSTR_VALID drops.
  - If NEXT_PC[1:0] == 2'b00, go to FETCH.
  - Otherwise MISALIGNED <= 1 and go to HALT.
- HALT:
  - IMEM_REQ = 0, INSTR_VALID = 0.
  - PC holds the misaligned value.
  - Only RESET exits this state.
- Ignored inputs:
  - PC_LOAD is ignored in IDLE, FETCH and HALT; an early retire pulse is dropped, not queued.
  - IMEM_ACK is ignored outside FETCH.
- Arithmetic:
  - PC_PLUS4 wraps: 32'hFFFF_FFFC -> 32'h0000_0000.
  - FETCH_COUNT wraps: 32'hFFFF_FFFF -> 0.
- Priority: RESET overrides everything, including a coincident IMEM_ACK or PC_LOAD. Those events are lost and their counter increments do not occur.

## Timing
- Reset: RESET high at edge N gives reset values after edge N. IMEM_REQ rises after the first edge with RESET low.
- Fetch latency:
  - ACK sampled at edge K gives INSTR and INSTR_VALID = 1 after edge K.
  - IMEM_REQ is low after edge K.
- Zero-wait memory (ACK in the first FETCH cycle) with PC_LOAD asserted in the first READY cycle: one instruction every 2 cycles.
- Each wait cycle of memory adds 1 cycle. Each cycle PC_LOAD is held low in READY adds 1 cycle.
- PC_LOAD at edge M:
  - New PC, IMEM_ADDR and PC_PLUS4 are visible after edge M.
  - IMEM_REQ is high in the cycle after edge M, unless the load entered HALT.
- Request stability: IMEM_REQ never drops, and IMEM_ADDR never changes, while in FETCH.
- Reset mid-fetch: IMEM_REQ is low in the cycle after the reset edge. Memory must tolerate the abandoned request.
- No combinational path from any input to any output.
  - Exception: PC_PLUS4 and IMEM_ADDR are combinational functions of the PC register only.

## Test plan
- Reset and first fetch:
  - Stimulus: RESET_VECTOR = 32'h0000_0100, RESET for 2 cycles, zero-wait memory returning 32'h0000_0013.
  - Response: IMEM_REQ rises one cycle after RESET falls with IMEM_ADDR = 0x100. INSTR = 0x13, INSTR_VALID = 1 one cycle later. PC_PLUS4 = 0x104. FETCH_COUNT = 1.
- Sequential stream:
  - Stimulus: PC_LOAD asserted every READY cycle, NEXT_PC = PC_PLUS4, zero-wait memory, 8 instructions.
  - Response: addresses 0x100..0x11C, one fetch every 2 cycles, FETCH_COUNT = 8.
- Wait states and ignored inputs:
  - Stimulus: ACK delayed 3 cycles; PC_LOAD pulsed during FETCH; ACK pulsed during READY.
  - Response: IMEM_REQ and IMEM_ADDR stable for 4 cycles. PC is unchanged by the early PC_LOAD. INSTR is unchanged by the stray ACK.
- Branch and misalignment:
  - Stimulus: NEXT_PC = 0x2000 on a load; later NEXT_PC = 0x2002 on a load.
  - Response: the first load fetches address 0x2000. The second gives MISALIGNED = 1, PC = 0x2002, IMEM_REQ held 0 indefinitely. RESET clears MISALIGNED and PC returns to RESET_VECTOR.
- Wrap-around:
  - Stimulus: load NEXT_PC = 32'hFFFF_FFFC; preload FETCH_COUNT near 32'hFFFF_FFFF via a long run or force.
  - Response: PC_PLUS4 = 0. The next load fetches address 0. FETCH_COUNT wraps to 0.
- Reset collisions:
  - Stimulus: RESET asserted in the same cycle as IMEM_ACK; in a separate run, RESET asserted in the same cycle as PC_LOAD.
  - Response: all outputs take reset values. FETCH_COUNT = 0. PC = RESET_VECTOR.
